// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit ripple slice per stage, with the
// higher operand chunks skewed forward and a single global advance enable for backpressure.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    localparam int SG = (STAGES < 1) ? 1 : STAGES;
    localparam int CW = WIDTH / SG;

    if (STAGES < 1 || (WIDTH % SG) != 0) begin : g_param_check
        $error("pipelined_add_sub: STAGES must be >= 1 and divide WIDTH");
    end

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;

    logic [SG-1:0]    vld, v_nxt;
    logic [SG-1:0]    c_r, c_nxt;
    logic [WIDTH-1:0] a_r   [SG];
    logic [WIDTH-1:0] b_r   [SG];
    logic [WIDTH-1:0] s_r   [SG];
    logic [WIDTH-1:0] a_nxt [SG];
    logic [WIDTH-1:0] b_nxt [SG];
    logic [WIDTH-1:0] s_nxt [SG];

    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, vi_in;
    logic [CW:0]      csum;
    logic             msb_cin, v_flag_nxt;
    logic             v_r, loaded;

    assign bx       = sub ? ~B : B;
    assign c0       = sub ? ~Cin : Cin;
    assign adv      = !vld[SG-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        a_in  = '0;
        b_in  = '0;
        s_in  = '0;
        c_in  = 1'b0;
        vi_in = 1'b0;
        csum  = '0;
        for (int unsigned k = 0; k < SG; k++) begin
            if (k == 0) begin
                a_in  = A;
                b_in  = bx;
                s_in  = '0;
                c_in  = c0;
                vi_in = in_valid;
            end else begin
                a_in  = a_r[k-1];
                b_in  = b_r[k-1];
                s_in  = s_r[k-1];
                c_in  = c_r[k-1];
                vi_in = vld[k-1];
            end
            csum = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_in[k*CW +: CW]} + {{CW{1'b0}}, c_in};
            s_in[k*CW +: CW] = csum[CW-1:0];
            a_nxt[k] = a_in;
            b_nxt[k] = b_in;
            s_nxt[k] = s_in;
            c_nxt[k] = csum[CW];
            v_nxt[k] = vi_in;
        end
        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        msb_cin    = a_nxt[SG-1][WIDTH-1] ^ b_nxt[SG-1][WIDTH-1] ^ s_nxt[SG-1][WIDTH-1];
        v_flag_nxt = msb_cin ^ c_nxt[SG-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= '0;
            c_r    <= '0;
            v_r    <= 1'b0;
            loaded <= 1'b0;
            for (int unsigned k = 0; k < SG; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else if (adv) begin
            vld <= v_nxt;
            // Data registers only load under a valid token, so bubbles leave flags untouched.
            for (int unsigned k = 0; k < SG; k++) begin
                if (v_nxt[k]) begin
                    a_r[k] <= a_nxt[k];
                    b_r[k] <= b_nxt[k];
                    s_r[k] <= s_nxt[k];
                    c_r[k] <= c_nxt[k];
                end
            end
            if (v_nxt[SG-1]) begin
                v_r    <= v_flag_nxt;
                loaded <= 1'b1;
            end
        end
    end

    assign out_valid = vld[SG-1];
    assign S         = s_r[SG-1];
    assign Cout      = c_r[SG-1];
    assign V         = v_r;
    assign Z         = loaded && (s_r[SG-1] == '0);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=32, STAGES=4): vector table with hand-computed results,
// a negedge scoreboard, and directed latency / streaming / backpressure / reset sequences.
module tb_pipelined_add_sub;

    localparam int W = 32;
    localparam int N = 4;
    localparam int NV = 10;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, V, Z;
    logic [W-1:0] A, B, S;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sb;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    vec_t tbl [NV];
    vec_t exp_q [$];
    vec_t f;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    int   cur    = 0;

    pipelined_add_sub #(.WIDTH(W), .STAGES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .V(V), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        A = tbl[i].a; B = tbl[i].b; Cin = tbl[i].cin; sub = tbl[i].sb;
        cur = i;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Scoreboard: transfers are decided by the levels seen half a cycle before the edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(tbl[cur]);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stale_result", {63'd0, out_valid}, 64'd0);
                end else begin
                    f = exp_q[0];
                    check("result", {29'd0, S, Cout, V, Z}, {29'd0, f.s, f.c, f.v, f.z});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        //          a             b             cin   sub   s             c     v     z
        tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        #2;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_flags", {29'd0, S, Cout, V, Z}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Latency: visible after the 4th edge counting the accept edge.
        drive(0);
        tick();
        idle();
        check("lat_edge0", {63'd0, out_valid}, 64'd0);
        tick();
        check("lat_edge1", {63'd0, out_valid}, 64'd0);
        tick();
        check("lat_edge2", {63'd0, out_valid}, 64'd0);
        tick();
        check("lat_edge3", {63'd0, out_valid}, 64'd1);
        tick();
        check("lat_single", {63'd0, out_valid}, 64'd0);

        // Streaming: 8 back-to-back ops, 8 results on consecutive cycles.
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(i); else idle();
            tick();
            check("stream_valid", {63'd0, out_valid}, {63'd0, (i >= 3 && i <= 10)});
        end

        // Backpressure: full pipe, stall 3 cycles, release with push and pop together.
        for (int i = 0; i < 4; i++) begin
            drive(2 + i);
            tick();
        end
        out_ready = 1'b0;
        drive(6);
        #1;
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
            check("bp_hold_S", {32'd0, S}, {32'd0, tbl[2].s});
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 12; i++) begin
            if (i < 4) drive(6 + i); else idle();
            tick();
            check("bp_drain_valid", {63'd0, out_valid}, {63'd0, (i <= 6)});
        end

        // Reset mid-flight: one result showing, three behind it.
        for (int i = 0; i < 4; i++) begin
            drive(2 + i);
            tick();
        end
        idle();
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_valid", {63'd0, out_valid}, 64'd0);
        check("rst_async_flags", {29'd0, S, Cout, V, Z}, 64'd0);
        check("rst_async_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_empty", {63'd0, out_valid}, 64'd0);
        end
        drive(6);
        tick();
        idle();
        repeat (2) tick();
        check("post_rst_pending", {63'd0, out_valid}, 64'd0);
        tick();
        check("post_rst_result", {63'd0, out_valid}, 64'd1);
        repeat (3) tick();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("result_count", 64'(pops), 64'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
